// File: rtl/lpc_record_serializer_if.sv
// Byte stream from the record serializer to the UART transmitter.
// The master drives out_byte/out_valid; the slave drives out_ready.
interface lpc_record_serializer_if;
    logic [7:0] out_byte;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_byte,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_byte,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/lpc_record_serializer.sv
// Buffers decoded LPC transactions in a record FIFO and serialises each one as a byte stream.
// Define LPC_SER_TRAILER_EN to append an 8'h0A delimiter byte after every record.
module lpc_record_serializer #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                      lpc_clock,
    input  logic                      lpc_reset,
    input  logic [3:0]                in_cyctype_dir,
    input  logic [31:0]               in_addr,
    input  logic [7:0]                in_data,
    input  logic                      in_strobe,
    lpc_record_serializer_if.master   out_if,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [7:0]                overflow_count,
    output logic                      busy
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned IDX_W = 3;
`ifdef LPC_SER_TRAILER_EN
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(6);
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(5);
`endif
    localparam logic [7:0] TRAILER = 8'h0A;

    typedef struct packed {
        logic [3:0]  cyctype_dir;
        logic [31:0] addr;
        logic [7:0]  data;
    } rec_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Byte i of the on-wire record image
    function automatic logic [7:0] byte_sel(input rec_t r, input logic [IDX_W-1:0] i);
        logic [7:0] b;
        case (i)
            IDX_W'(0): b = {4'h0, r.cyctype_dir};
            IDX_W'(1): b = r.addr[31:24];
            IDX_W'(2): b = r.addr[23:16];
            IDX_W'(3): b = r.addr[15:8];
            IDX_W'(4): b = r.addr[7:0];
            IDX_W'(5): b = r.data;
            default:   b = TRAILER;
        endcase
        return b;
    endfunction

    rec_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   level;
    state_t          state;
    rec_t            shift_rec;
    logic [IDX_W-1:0] idx;
    logic [7:0]      out_byte_q;
    logic            out_valid_q;
    logic [7:0]      ovf_q;
    logic            busy_q;

    rec_t            in_rec_c;
    rec_t            head_c;
    logic            fifo_empty_c;
    logic            fifo_full_c;
    logic            accept_c;
    logic            last_c;
    logic            pop_c;
    logic            push_c;
    logic            drop_c;
    logic [LW-1:0]   level_nxt_c;
    logic            valid_nxt_c;

    // FIFO and handshake decisions for the coming edge
    always_comb begin
        in_rec_c     = '{cyctype_dir: in_cyctype_dir, addr: in_addr, data: in_data};
        head_c       = mem[rd_ptr];
        fifo_empty_c = (level == '0);
        fifo_full_c  = (level == LW'(DEPTH));
        accept_c     = (state == SEND) && out_if.out_ready;
        last_c       = (idx == LAST_IDX);
        pop_c        = !fifo_empty_c && ((state == IDLE) || (accept_c && last_c));
        push_c       = in_strobe && (!fifo_full_c || pop_c);
        drop_c       = in_strobe && fifo_full_c && !pop_c;
        level_nxt_c  = level + LW'(push_c) - LW'(pop_c);
        valid_nxt_c  = pop_c || ((state == SEND) && !(accept_c && last_c));
    end

    // Record storage carries no reset; occupancy is tracked by level
    always_ff @(posedge lpc_clock) begin
        if (push_c) begin
            mem[wr_ptr] <= in_rec_c;
        end
    end

    always_ff @(posedge lpc_clock or posedge lpc_reset) begin
        if (lpc_reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            ovf_q       <= '0;
            busy_q      <= 1'b0;
            state       <= IDLE;
            shift_rec   <= '0;
            idx         <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt_c;
            if (drop_c && (ovf_q != 8'hFF)) begin
                ovf_q <= ovf_q + 8'd1;
            end
            busy_q      <= valid_nxt_c || (level_nxt_c != '0);
            out_valid_q <= valid_nxt_c;

            // A pop always reloads the shift register, which gives the no-bubble handoff
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        shift_rec  <= head_c;
                        idx        <= '0;
                        out_byte_q <= byte_sel(head_c, '0);
                        state      <= SEND;
                    end
                end
                SEND: begin
                    if (pop_c) begin
                        shift_rec  <= head_c;
                        idx        <= '0;
                        out_byte_q <= byte_sel(head_c, '0);
                    end else if (accept_c) begin
                        if (last_c) begin
                            state <= IDLE;
                        end else begin
                            idx        <= idx + IDX_W'(1);
                            out_byte_q <= byte_sel(shift_rec, idx + IDX_W'(1));
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign out_if.out_byte  = out_byte_q;
    assign out_if.out_valid = out_valid_q;
    assign fifo_level       = level;
    assign overflow_count   = ovf_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_lpc_record_serializer.sv
// Self-checking bench for lpc_record_serializer: directed scenarios plus randomized traffic
// against a queue-based reference model.
module tb_lpc_record_serializer;

    localparam int DEPTH = 8;
`ifdef LPC_SER_TRAILER_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif
    localparam int LAST = NB - 1;

    logic        lpc_clock;
    logic        lpc_reset;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic        in_strobe;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [7:0]  overflow_count;
    logic        busy;

    lpc_record_serializer_if bus ();

    lpc_record_serializer #(.DEPTH(DEPTH)) dut (
        .lpc_clock      (lpc_clock),
        .lpc_reset      (lpc_reset),
        .in_cyctype_dir (in_cyctype_dir),
        .in_addr        (in_addr),
        .in_data        (in_data),
        .in_strobe      (in_strobe),
        .out_if         (bus),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .busy           (busy)
    );

    initial lpc_clock = 1'b0;
    always #5 lpc_clock = ~lpc_clock;

    int checks = 0;
    int errors = 0;

    // Reference model: waiting records, the record on the wire and its byte position
    logic [43:0] q [$];
    logic [43:0] m_rec;
    bit          m_valid;
    int          m_idx;
    int          m_ovf;

    function automatic logic [7:0] exp_byte(input logic [43:0] r, input int i);
        logic [7:0] b;
        case (i)
            0:       b = {4'h0, r[43:40]};
            1:       b = r[39:32];
            2:       b = r[31:24];
            3:       b = r[23:16];
            4:       b = r[15:8];
            5:       b = r[7:0];
            default: b = 8'h0A;
        endcase
        return b;
    endfunction

    task automatic clear_model();
        q.delete();
        m_valid = 0;
        m_idx   = 0;
        m_ovf   = 0;
        m_rec   = '0;
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge, settle 1 unit
    task automatic step(input logic s, input logic [3:0] ct, input logic [31:0] a,
                        input logic [7:0] d, input logic r);
        int lvl;
        bit pop;
        bit full;
        @(negedge lpc_clock);
        in_strobe      = s;
        in_cyctype_dir = ct;
        in_addr        = a;
        in_data        = d;
        bus.out_ready  = r;
        @(posedge lpc_clock);
        lvl  = q.size();
        pop  = (lvl != 0) && (!m_valid || (r && m_idx == LAST));
        full = (lvl == DEPTH);
        if (m_valid && r) begin
            if (m_idx == LAST) m_valid = 0;
            else m_idx++;
        end
        if (pop) begin
            m_rec   = q.pop_front();
            m_idx   = 0;
            m_valid = 1;
        end
        if (s) begin
            if (!full || pop) q.push_back({ct, a, d});
            else if (m_ovf < 255) m_ovf++;
        end
        #1;
    endtask

    task automatic apply_reset();
        in_strobe = 1'b0;
        bus.out_ready = 1'b0;
        lpc_reset = 1'b1;
        clear_model();
        @(negedge lpc_clock);
        @(negedge lpc_clock);
        lpc_reset = 1'b0;
    endtask

    function automatic void seq_init(output logic [7:0] s [7], input logic [43:0] r);
        for (int i = 0; i < 7; i++) s[i] = exp_byte(r, i);
    endfunction

    task automatic test_reset();
        lpc_reset = 1'b0;
        in_strobe = 1'b0;
        in_cyctype_dir = '0;
        in_addr = '0;
        in_data = '0;
        bus.out_ready = 1'b0;
        #1;
        lpc_reset = 1'b1;
        clear_model();
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", bus.out_byte); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (overflow_count !== 8'h00) begin errors++; $display("FAIL reset_ovf got %0d want 0", overflow_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge lpc_clock);
        lpc_reset = 1'b0;
    endtask

    task automatic test_single();
        logic [7:0] s [7];
        seq_init(s, {4'h0, 32'h00007FE5, 8'h6C});
        step(1'b1, 4'h0, 32'h00007FE5, 8'h6C, 1'b1);
        checks++; if (fifo_level !== 4'd1) begin errors++; $display("FAIL single_level_after_push got %0d want 1", fifo_level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got %b want 0", bus.out_valid); end
        for (int i = 0; i < NB; i++) begin
            step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== s[i]) begin
                errors++; $display("FAIL single_byte%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_byte, s[i]);
            end
            if (i == 0) begin
                checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL single_level_after_pop got %0d want 0", fifo_level); end
            end
        end
        step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_valid_end got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] s [7];
        seq_init(s, {4'h0, 32'h00007FE5, 8'h6C});
        step(1'b1, 4'h0, 32'h00007FE5, 8'h6C, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== s[i]) begin
                errors++; $display("FAIL bp_byte%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_byte, s[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'h0, 32'h0, 8'h0, 1'b0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h00) begin
                errors++; $display("FAIL bp_hold%0d got v=%b %h want v=1 00", i, bus.out_valid, bus.out_byte);
            end
        end
        for (int i = 3; i < NB; i++) begin
            step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== s[i]) begin
                errors++; $display("FAIL bp_byte%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_byte, s[i]);
            end
        end
        step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_end got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s1 [7];
        logic [7:0] s2 [7];
        logic [7:0] want;
        seq_init(s1, {4'h0, 32'h11223344, 8'hAA});
        seq_init(s2, {4'h0, 32'h55667788, 8'hBB});
        step(1'b1, 4'h0, 32'h11223344, 8'hAA, 1'b1);
        step(1'b1, 4'h0, 32'h55667788, 8'hBB, 1'b1);
        for (int i = 0; i < 2 * NB; i++) begin
            if (i > 0) step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
            want = (i < NB) ? s1[i] : s2[i - NB];
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_byte !== want) begin
                errors++; $display("FAIL b2b_byte%0d got v=%b %h want v=1 %h", i, bus.out_valid, bus.out_byte, want);
            end
        end
        step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_end got %b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        logic [43:0] recs [10];
        logic [7:0]  got [$];
        bit          bad;
        for (int i = 0; i < 10; i++) recs[i] = {4'($urandom), 32'($urandom), 8'($urandom)};
        for (int i = 0; i < 10; i++) step(1'b1, recs[i][43:40], recs[i][39:8], recs[i][7:0], 1'b0);
        checks++; if (fifo_level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d want 8", fifo_level); end
        checks++; if (overflow_count !== 8'd1) begin errors++; $display("FAIL ovf_count got %0d want 1", overflow_count); end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== exp_byte(recs[0], 0)) begin
            errors++; $display("FAIL ovf_head got v=%b %h want v=1 %h", bus.out_valid, bus.out_byte, exp_byte(recs[0], 0));
        end
        for (int n = 0; n < 9 * NB + 12; n++) begin
            if (bus.out_valid === 1'b1) got.push_back(bus.out_byte);
            step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
        end
        checks++; if (got.size() != 9 * NB) begin errors++; $display("FAIL ovf_drain_len got %0d want %0d", got.size(), 9 * NB); end
        for (int r = 0; r < 9; r++) begin
            bad = 0;
            for (int j = 0; j < NB; j++)
                if (r * NB + j >= got.size() || got[r * NB + j] !== exp_byte(recs[r], j)) bad = 1;
            checks++; if (bad) begin errors++; $display("FAIL ovf_drain_rec%0d got mismatching bytes want record %h", r, recs[r]); end
        end
        checks++; if (fifo_level !== 4'd0) begin errors++; $display("FAIL ovf_level_drained got %0d want 0", fifo_level); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 4'h3, 32'h00007FE5, 8'h6C, 1'b1);
        step(1'b1, 4'h1, 32'hCAFE0001, 8'h01, 1'b1);
        step(1'b1, 4'h2, 32'hCAFE0002, 8'h02, 1'b1);
        step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
        step(1'b0, 4'h0, 32'h0, 8'h0, 1'b1);
        #2;
        lpc_reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", bus.out_valid); end
        checks++; if (fifo_level !== '0) begin errors++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
        checks++; if (overflow_count !== 8'h00) begin errors++; $display("FAIL rstmid_ovf got %0d want 0", overflow_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        in_strobe = 1'b0;
        clear_model();
        @(negedge lpc_clock);
        lpc_reset = 1'b0;
        step(1'b1, 4'h5, 32'h89ABCDEF, 8'h42, 1'b0);
        step(1'b0, 4'h0, 32'h0, 8'h0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_byte !== 8'h05) begin
            errors++; $display("FAIL rstmid_clean_b0 got v=%b %h want v=1 05", bus.out_valid, bus.out_byte);
        end
    endtask

    task automatic test_random();
        int thr [4] = '{85, 10, 50, 30};
        int sp  [4] = '{40, 60, 30, 80};
        logic s;
        logic r;
        apply_reset();
        for (int p = 0; p < 4; p++) begin
            for (int c = 0; c < 150; c++) begin
                s = ($urandom_range(99, 0) < sp[p]);
                r = ($urandom_range(99, 0) < thr[p]);
                step(s, 4'($urandom), 32'($urandom), 8'($urandom), r);
                checks++;
                if (bus.out_valid !== m_valid) begin
                    errors++; $display("FAIL rnd_valid t=%0t got %b want %b", $time, bus.out_valid, m_valid);
                end
                if (m_valid) begin
                    checks++;
                    if (bus.out_byte !== exp_byte(m_rec, m_idx)) begin
                        errors++; $display("FAIL rnd_byte t=%0t got %h want %h", $time, bus.out_byte, exp_byte(m_rec, m_idx));
                    end
                end
                checks++;
                if (fifo_level !== q.size()) begin
                    errors++; $display("FAIL rnd_level t=%0t got %0d want %0d", $time, fifo_level, q.size());
                end
                checks++;
                if (overflow_count !== 8'(m_ovf)) begin
                    errors++; $display("FAIL rnd_ovf t=%0t got %0d want %0d", $time, overflow_count, m_ovf);
                end
                checks++;
                if (busy !== (m_valid || q.size() != 0)) begin
                    errors++; $display("FAIL rnd_busy t=%0t got %b want %b", $time, busy, (m_valid || q.size() != 0));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lpc_record_serializer.md
Name: lpc_record_serializer

Overview:
Sits directly downstream of the lpc decoder. Captures each decoded LPC transaction (cycle type/direction, address, data) on the decoder's output clock-enable strobe and buffers it in a small record FIFO. It then serialises each record as a fixed byte sequence over a valid/ready byte interface that feeds the UART transmitter. It absorbs bursts of LPC cycles while the slower byte sink drains.

Parameters:
DEPTH, 8, record FIFO depth in records; power of two, minimum 2.

Ports:
lpc_clock  input  1  sole clock, rising edge; the LPC clock domain.
lpc_reset  input  1  asynchronous, active-high reset.
in_cyctype_dir  input  4  cycle type/direction nibble from the decoder.
in_addr  input  32  decoded address from the decoder.
in_data  input  8  decoded data byte from the decoder.
in_strobe  input  1  one-cycle record-valid pulse; connects to the decoder's out_clock_enable.
out_byte  output  8  serial byte to the sink.
out_valid  output  1  out_byte is valid.
out_ready  input  1  sink accepts out_byte this cycle.
fifo_level  output  $clog2(DEPTH)+1  number of records currently held in the FIFO.
overflow_count  output  8  saturating count of dropped records.
busy  output  1  high while a record is being serialised or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous, lpc_reset=1): FIFO empties; out_valid=0, out_byte=0, fifo_level=0, overflow_count=0, busy=0. Any partially sent record is discarded. Normal operation resumes on the first rising edge after deassertion.
- Record format, 44 bits: {cyctype_dir[3:0], addr[31:0], data[7:0]}. All three inputs are sampled on the edge where in_strobe=1.
- Byte sequence per record, 6 bytes: B0={4'h0, cyctype_dir}; B1=addr[31:24]; B2=addr[23:16]; B3=addr[15:8]; B4=addr[7:0]; B5=data.
- Push: on an edge with in_strobe=1 and the FIFO not full, the record is written and fifo_level increments.
- Full FIFO with in_strobe=1 and no pop on the same edge: the record is dropped and overflow_count increments. overflow_count saturates at 8'hFF.
- Full FIFO with in_strobe=1 and a pop on the same edge: the push is accepted and fifo_level is unchanged.
- Serialiser FSM states: IDLE and SEND.
  - IDLE: if the FIFO is non-empty, pop the head record into the output shift register on the next edge. Then set byte index=0, out_valid=1, out_byte=B0, and go to SEND.
  - SEND: out_byte and out_valid are held stable while out_valid && !out_ready. On each edge with out_ready=1, advance to the next byte.
  - After the last byte is accepted: if the FIFO is non-empty, load the next record on that same edge with no bubble, keeping out_valid=1 with the new B0. Otherwise go to IDLE with out_valid=0.
- Latency: a strobe at edge k into an empty, idle block gives fifo_level=1 after edge k. The pop happens at edge k+1, so out_valid=1 with B0 after edge k+1 and fifo_level returns to 0.
- Simultaneous push and pop on a non-full FIFO: fifo_level is unchanged.
- FIFO pointers are log2(DEPTH) bits wide and wrap naturally. fifo_level is a separate counter that distinguishes full from empty.
- busy = out_valid | (fifo_level != 0).
- An in_strobe pulse held for more than one cycle is treated as multiple records; each high cycle is a push.

Optional Feature:
LPC_SER_TRAILER_EN
- Defined: a 7th byte B6=8'h0A is appended to every record as a record delimiter, and the last-byte index becomes 6.
- Undefined: records are exactly 6 bytes (B0-B5). No other behaviour changes.

Test Plan:
- Single record, out_ready held 1: strobe with ct_dir=0, addr=0x00007FE5, data=0x6C -> bytes 00,00,00,7F,E5,6C on consecutive cycles. First byte is valid at strobe edge+1; out_valid drops after the 6th byte.
- Backpressure: same record with out_ready low for 3 cycles at B2 -> out_byte stays 0x00 and out_valid stays 1 throughout; the sequence completes unchanged after out_ready returns.
- Back-to-back: two strobes one cycle apart (addr 0x11223344/data 0xAA, addr 0x55667788/data 0xBB) with out_ready=1 -> 12 contiguous bytes with no gap in out_valid.
- Overflow with DEPTH=8, out_ready=0: 10 strobes -> fifo_level=8, overflow_count=1 after the 10th; the first record stays latched in the shift register. Drain -> exactly 9 records emitted, matching strobes 1-9.
- Reset mid-record: assert lpc_reset asynchronously after B2 is accepted -> out_valid=0, fifo_level=0, overflow_count=0 immediately. A new strobe after release emits a clean B0.
- With LPC_SER_TRAILER_EN defined: the single-record case emits 00,00,00,7F,E5,6C,0A.
